// File: rtl/lms_pkg.sv
// Shared types and the saturation helper for the LMS weight-update engine.
package lms_pkg;

    typedef enum logic [1:0] {
        MODE_LMS      = 2'd0,
        MODE_SIGN_ERR = 2'd1,
        MODE_LEAKY    = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int SAT_W = 64;

    // Clamps a sign-extended value into a signed field of 'width' bits and reports a clip.
    function automatic logic signed [SAT_W-1:0] sat_to_width(
        input  logic signed [SAT_W-1:0] val,
        input  int                      width,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = SAT_W'(1);
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
        if (val > hi) begin
            sat_to_width = hi;
            clipped      = 1'b1;
        end else if (val < lo) begin
            sat_to_width = lo;
            clipped      = 1'b1;
        end else begin
            sat_to_width = val;
            clipped      = 1'b0;
        end
    endfunction

endpackage

// File: rtl/lms_tap_datapath.sv
// Two-stage per-tap datapath: error*sample product, then step scaling, leak,
// accumulate and saturate against the current weight of the same tap.
module lms_tap_datapath #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int LEAK_SHIFT = 6,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [WIDTH-1:0] error,
    input  logic signed [WIDTH-1:0] step_size,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] weight,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovr
);
    import lms_pkg::*;

    localparam int PROD_W = 2 * WIDTH;
    localparam int Q_W    = 3 * WIDTH;
    localparam int SUM_W  = 3 * WIDTH + 2;
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

    logic signed [WIDTH-1:0]  e_eff;
    logic signed [PROD_W-1:0] s1_prod;
    logic                     s1_valid;
    logic [IDX_W-1:0]         s1_idx;
    logic signed [Q_W-1:0]    q;
    logic signed [Q_W:0]      off;
    logic signed [WIDTH-1:0]  w_eff;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;

    // Sign-error mode replaces the error by +/-1.0 (or 0) before the product.
    always_comb begin
        e_eff = error;
        if (mode == MODE_SIGN_ERR) begin
            if (error > 0)
                e_eff = ONE;
            else if (error < 0)
                e_eff = -ONE;
            else
                e_eff = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= in_valid && !flush;
            if (in_valid) begin
                s1_idx  <= in_idx;
                s1_prod <= PROD_W'(e_eff) * PROD_W'(sample);
            end
        end
    end

    // The weight is re-aligned to 3*FRAC fraction bits so the sum is exact before the floor shift.
    always_comb begin
        q       = Q_W'(s1_prod) * Q_W'(step_size);
        off     = $signed({q, 1'b0});
        w_eff   = weight;
        if (mode == MODE_LEAKY)
            w_eff = weight - (weight >>> LEAK_SHIFT);
        sum     = (SUM_W'(w_eff) <<< (2 * FRAC)) + SUM_W'(off);
        shifted = sum >>> (2 * FRAC);
        ovr     = 1'b0;
        result  = WIDTH'(sat_to_width(SAT_W'(shifted), WIDTH, ovr));
    end

    assign out_valid = s1_valid;
    assign out_idx   = s1_idx;

endmodule

// File: rtl/lms_weight_engine.sv
// LMS weight-update engine: owns the weight register file and walks one tap per
// cycle through the tap datapath for every accepted sample vector.
module lms_weight_engine #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int TAPS       = 8,
    parameter int LEAK_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAPS*WIDTH-1:0]   din,
    input  logic signed [WIDTH-1:0] error,
    input  logic signed [WIDTH-1:0] step_size,
    input  logic [1:0]              mode,
    input  logic                    weight_clr,
    output logic [TAPS*WIDTH-1:0]   weights,
    output logic [TAPS-1:0]         weights_ovr,
    output logic                    upd_done
);
    import lms_pkg::*;

    localparam int IDX_W = $clog2(TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        idx;
    logic [TAPS*WIDTH-1:0]   din_q;
    logic signed [WIDTH-1:0] error_q;
    logic signed [WIDTH-1:0] step_q;
    logic [1:0]              mode_q;
    logic                    accept;
    logic                    issue;
    logic                    dp_valid;
    logic [IDX_W-1:0]        dp_idx;
    logic signed [WIDTH-1:0] dp_result;
    logic                    dp_ovr;

    // A clear arriving with a request wins; the request is dropped.
    assign accept = in_valid && in_ready && !weight_clr;

    // DRAIN lasts one cycle: the last tap retires from stage 2 while there.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN: begin
                issue = 1'b1;
                if (idx == LAST_IDX) next_state = DRAIN;
            end
            DRAIN:   next_state = DONE;
            DONE:    next_state = accept ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
        if (weight_clr) begin
            next_state = IDLE;
            issue      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            upd_done <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == IDLE) || (next_state == DONE);
            upd_done <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            din_q   <= '0;
            error_q <= '0;
            step_q  <= '0;
            mode_q  <= MODE_LMS;
        end else if (accept) begin
            idx     <= '0;
            din_q   <= din;
            error_q <= error;
            step_q  <= step_size;
            mode_q  <= mode;
        end else if (issue) begin
            idx <= idx + 1'b1;
        end
    end

    lms_tap_datapath #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .LEAK_SHIFT (LEAK_SHIFT),
        .IDX_W      (IDX_W)
    ) u_tap (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (weight_clr),
        .in_valid  (issue),
        .in_idx    (idx),
        .sample    (din_q[idx*WIDTH +: WIDTH]),
        .error     (error_q),
        .step_size (step_q),
        .mode      (mode_q),
        .weight    (weights[dp_idx*WIDTH +: WIDTH]),
        .out_valid (dp_valid),
        .out_idx   (dp_idx),
        .result    (dp_result),
        .ovr       (dp_ovr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights     <= '0;
            weights_ovr <= '0;
        end else if (weight_clr) begin
            weights     <= '0;
            weights_ovr <= '0;
        end else if (dp_valid) begin
            weights[dp_idx*WIDTH +: WIDTH] <= dp_result;
            if (dp_ovr)
                weights_ovr[dp_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lms_weight_engine.sv
// Directed, table-driven bench for lms_weight_engine (TAPS=4, LEAK_SHIFT=4, 1.0=16384)
// plus hand-written handshake, abort, reset and clear-vs-accept sequences.
module tb_lms_weight_engine;
    import lms_pkg::*;

    localparam int WIDTH      = 16;
    localparam int FRAC       = 14;
    localparam int TAPS       = 4;
    localparam int LEAK_SHIFT = 4;
    localparam int NVEC       = 15;

    logic                    clk        = 1'b0;
    logic                    rst_n      = 1'b0;
    logic                    in_valid   = 1'b0;
    logic                    in_ready;
    logic [TAPS*WIDTH-1:0]   din        = '0;
    logic signed [WIDTH-1:0] error      = '0;
    logic signed [WIDTH-1:0] step_size  = '0;
    logic [1:0]              mode       = 2'b00;
    logic                    weight_clr = 1'b0;
    logic [TAPS*WIDTH-1:0]   weights;
    logic [TAPS-1:0]         weights_ovr;
    logic                    upd_done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic             clr;
        logic [1:0]       mode;
        logic [3:0][15:0] din;
        logic [15:0]      err;
        logic [15:0]      step;
        logic [3:0][15:0] exp_w;
        logic [3:0]       exp_ovr;
    } vec_t;

    vec_t vecs [NVEC];

    lms_weight_engine #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .TAPS       (TAPS),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din         (din),
        .error       (error),
        .step_size   (step_size),
        .mode        (mode),
        .weight_clr  (weight_clr),
        .weights     (weights),
        .weights_ovr (weights_ovr),
        .upd_done    (upd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic clr, input logic [1:0] m,
                                input int d0, input int d1, input int d2, input int d3,
                                input int e, input int s,
                                input int w0, input int w1, input int w2, input int w3,
                                input logic [3:0] ovr);
        vec_t v;
        v.clr      = clr;
        v.mode     = m;
        v.din[0]   = 16'(d0);
        v.din[1]   = 16'(d1);
        v.din[2]   = 16'(d2);
        v.din[3]   = 16'(d3);
        v.err      = 16'(e);
        v.step     = 16'(s);
        v.exp_w[0] = 16'(w0);
        v.exp_w[1] = 16'(w1);
        v.exp_w[2] = 16'(w2);
        v.exp_w[3] = 16'(w3);
        v.exp_ovr  = ovr;
        return v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic int weight_of(input int t);
        return int'($signed(weights[t*WIDTH +: WIDTH]));
    endfunction

    task automatic do_clear();
        @(negedge clk);
        weight_clr = 1'b1;
        @(negedge clk);
        weight_clr = 1'b0;
    endtask

    // Drives one request on cycle 0 and returns the cycle on which upd_done is seen (-1 on timeout).
    task automatic apply_stimulus(input logic [TAPS*WIDTH-1:0] d, input logic [WIDTH-1:0] e,
                                  input logic [WIDTH-1:0] s, input logic [1:0] m, output int lat);
        int cyc;
        @(negedge clk);
        din       = d;
        error     = e;
        step_size = s;
        mode      = m;
        in_valid  = 1'b1;
        check_output("ready_at_accept", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!upd_done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        lat = upd_done ? cyc : -1;
    endtask

    task automatic preload_saturated();
        int lat;
        do_clear();
        apply_stimulus({16'd0, 16'd0, 16'd0, 16'd16384}, 16'd16384, 16'd16384, MODE_LMS, lat);
        check_output("preload_ovr", int'(weights_ovr), 1);
    endtask

    task automatic check_cleared(input string tag);
        for (int t = 0; t < TAPS; t++)
            check_output($sformatf("%s_w%0d", tag, t), weight_of(t), 0);
        check_output({tag, "_ovr"}, int'(weights_ovr), 0);
        check_output({tag, "_ready"}, int'(in_ready), 1);
        check_output({tag, "_done"}, int'(upd_done), 0);
    endtask

    task automatic count_pulses(input string tag);
        int pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (upd_done) pulses++;
        end
        check_output({tag, "_no_done"}, pulses, 0);
    endtask

    // Starts an update and interrupts it on cycle 3 with either weight_clr or rst_n.
    task automatic interrupt_update(input logic use_reset, input string tag);
        preload_saturated();
        @(negedge clk);
        din       = {4{16'd8192}};
        error     = 16'sd8192;
        step_size = 16'sd4096;
        mode      = MODE_LMS;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (use_reset) rst_n = 1'b0;
        else           weight_clr = 1'b1;
        @(negedge clk);
        rst_n      = 1'b1;
        weight_clr = 1'b0;
        check_cleared(tag);
        count_pulses(tag);
    endtask

    initial begin
        int lat;
        int cyc;

        vecs[0]  = mk(1, MODE_LMS,      8192, 0, 0, -8192,   8192,  4096,   2048, 0, 0, -2048,   4'b0000);
        vecs[1]  = mk(1, MODE_LMS,     16384, 0, 0, 0,      16384, 16000,  32000, 0, 0, 0,       4'b0000);
        vecs[2]  = mk(0, MODE_LMS,     16384, 0, 0, 0,      16384, 16384,  32767, 0, 0, 0,       4'b0001);
        vecs[3]  = mk(0, MODE_LMS,     16384, 0, 0, 0,          0, 16384,  32767, 0, 0, 0,       4'b0001);
        vecs[4]  = mk(1, MODE_SIGN_ERR, 8192, -8192, 16384, 0,  -3, 4096,  -4096, 4096, -8192, 0, 4'b0000);
        vecs[5]  = mk(0, MODE_SIGN_ERR, 8192, -8192, 16384, 0,   0, 4096,  -4096, 4096, -8192, 0, 4'b0000);
        vecs[6]  = mk(0, MODE_SIGN_ERR, 8192, 0, 0, 0,           5, 4096,      0, 4096, -8192, 0, 4'b0000);
        vecs[7]  = mk(1, MODE_LMS,     16384, 0, 0, 0,      16384,  8192,  16384, 0, 0, 0,       4'b0000);
        vecs[8]  = mk(0, MODE_LEAKY,   16384, 0, 0, 0,          0,  8192,  15360, 0, 0, 0,       4'b0000);
        vecs[9]  = mk(0, MODE_LEAKY,   16384, 0, 0, 0,          0,  8192,  14400, 0, 0, 0,       4'b0000);
        vecs[10] = mk(1, MODE_LMS,    -16384, 16384, 0, 0,  16384, 16383, -32766, 32766, 0, 0,   4'b0000);
        vecs[11] = mk(0, MODE_LMS,    -16384, 16384, 0, 0,  16384, 16383, -32768, 32767, 0, 0,   4'b0011);
        vecs[12] = mk(1, MODE_LMS,         1, -1, 0, 0,         1,     1,      0, -1, 0, 0,      4'b0000);
        vecs[13] = mk(0, MODE_LEAKY,       1, -1, 0, 0,         0,     1,      0, 0, 0, 0,       4'b0000);
        vecs[14] = mk(1, 2'b11,         8192, 0, 0, -8192,   8192,  4096,   2048, 0, 0, -2048,   4'b0000);

        @(negedge clk);
        check_output("reset_ready", int'(in_ready), 1);
        check_output("reset_done", int'(upd_done), 0);
        check_output("reset_ovr", int'(weights_ovr), 0);
        for (int t = 0; t < TAPS; t++)
            check_output($sformatf("reset_w%0d", t), weight_of(t), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].clr) do_clear();
            apply_stimulus(vecs[i].din, vecs[i].err, vecs[i].step, vecs[i].mode, lat);
            check_output($sformatf("v%0d_latency", i), lat, 6);
            for (int t = 0; t < TAPS; t++)
                check_output($sformatf("v%0d_w%0d", i, t), weight_of(t),
                             int'($signed(vecs[i].exp_w[t])));
            check_output($sformatf("v%0d_ovr", i), int'(weights_ovr), int'(vecs[i].exp_ovr));
        end

        // in_valid held high: accepts land on cycles 0, 6 and 12 only.
        do_clear();
        @(negedge clk);
        din       = '0;
        error     = '0;
        step_size = 16'sd4096;
        mode      = MODE_LMS;
        in_valid  = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            check_output($sformatf("hs_ready_c%0d", c), int'(in_ready), (c % 6 == 0) ? 1 : 0);
            check_output($sformatf("hs_done_c%0d", c), int'(upd_done), (c == 6 || c == 12) ? 1 : 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        cyc = 13;
        while (!upd_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_output("hs_third_done_cycle", upd_done ? cyc : -1, 18);

        interrupt_update(1'b0, "abort_clr");
        interrupt_update(1'b1, "abort_rst");

        // Clear together with a request: the request must be dropped.
        preload_saturated();
        @(negedge clk);
        din        = {4{16'd8192}};
        error      = 16'sd8192;
        step_size  = 16'sd4096;
        mode       = MODE_LMS;
        in_valid   = 1'b1;
        weight_clr = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        weight_clr = 1'b0;
        check_cleared("clr_accept");
        count_pulses("clr_accept");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
